// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR ADC digital controller.
// Bit vectors are declared [0:N_BITS-1] so index 0 is the MSB.
package sar_pkg;

    localparam int N_BITS = 10;

    typedef enum logic [1:0] {
        SAMPLE,
        CONV,
        DONE
    } sar_state_t;

    typedef logic [0:N_BITS-1] sar_word_t;

    localparam sar_word_t MSB_FLAG = {1'b1, {(N_BITS-1){1'b0}}};

endpackage

// File: rtl/sar_if.sv
// Comparator inputs and DAC/result outputs of the SAR controller.
// The master modport is the controller; the slave modport is the analog front end.
interface sar_if;
    import sar_pkg::*;

    logic      COMP_P;
    logic      COMP_N;
    logic      CLKS;
    logic      CLKSB;
    logic      EOC;
    sar_word_t CF;
    sar_word_t DOUT;
    sar_word_t CDAC_P;
    sar_word_t CDAC_N;

    modport master (
        input  COMP_P, COMP_N,
        output CLKS, CLKSB, EOC, CF, DOUT, CDAC_P, CDAC_N
    );

    modport slave (
        output COMP_P, COMP_N,
        input  CLKS, CLKSB, EOC, CF, DOUT, CDAC_P, CDAC_N
    );

endinterface

// File: rtl/sar_bit_seq.sv
// One-hot bit-cycle sequencer: loads the MSB flag on start, walks towards the
// LSB one position per clock, and empties itself after the last bit.
module sar_bit_seq
    import sar_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start,
    output sar_word_t cf,
    output logic      last
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cf <= '0;
        end else if (start) begin
            cf <= MSB_FLAG;
        end else begin
            cf <= cf >> 1;
        end
    end

    assign last = cf[N_BITS-1];

endmodule

// File: rtl/sar_controller.sv
// Free-running SAR conversion FSM: SAMPLE -> CONV (one bit per cycle) -> DONE,
// driving monotonic CDAC switching and publishing the result with an EOC strobe.
module sar_controller
    import sar_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic      CLK,
    input  logic      RST,
    sar_if.master     bus
);

    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    sar_state_t       state;
    logic [CNT_W-1:0] sample_cnt;
    logic             clks;
    logic             eoc;
    sar_word_t        result;
    sar_word_t        dout;
    sar_word_t        cdac_p;
    sar_word_t        cdac_n;
    sar_word_t        cf;
    logic             last_bit;
    logic             sample_done;
    sar_word_t        set_p;
    sar_word_t        set_n;

    assign sample_done = (sample_cnt == CNT_W'(SAMPLE_CYCLES - 1));

    sar_bit_seq u_bit_seq (
        .clk   (CLK),
        .rst_n (RST),
        .start (state == SAMPLE && sample_done),
        .cf    (cf),
        .last  (last_bit)
    );

    // The active CF bit selects which switch closes; the decision uses COMP_P only.
    assign set_p = bus.COMP_P ? cf : '0;
    assign set_n = bus.COMP_P ? '0 : cf;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= SAMPLE;
            sample_cnt <= '0;
            clks       <= 1'b1;
            eoc        <= 1'b0;
            result     <= '0;
            dout       <= '0;
            cdac_p     <= '0;
            cdac_n     <= '0;
        end else begin
            eoc <= 1'b0;
            unique case (state)
                SAMPLE: begin
                    result <= '0;
                    cdac_p <= '0;
                    cdac_n <= '0;
                    if (sample_done) begin
                        sample_cnt <= '0;
                        clks       <= 1'b0;
                        state      <= CONV;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                CONV: begin
                    result <= result | set_p;
                    cdac_p <= cdac_p | set_p;
                    cdac_n <= cdac_n | set_n;
                    if (last_bit) begin
                        dout  <= result | set_p;
                        eoc   <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Both arrays return to reset as the input is tracked again.
                    clks   <= 1'b1;
                    result <= '0;
                    cdac_p <= '0;
                    cdac_n <= '0;
                    state  <= SAMPLE;
                end
                default: state <= SAMPLE;
            endcase
        end
    end

    assign bus.CLKS   = clks;
    assign bus.CLKSB  = ~clks;
    assign bus.EOC    = eoc;
    assign bus.CF     = cf;
    assign bus.DOUT   = dout;
    assign bus.CDAC_P = cdac_p;
    assign bus.CDAC_N = cdac_n;

endmodule

// File: tb/tb_sar_controller.sv
// Directed bench for sar_controller: reset, constant and patterned comparator
// decisions, randomised invariant sweep, and comparator tie with mid-conversion reset.
module tb_sar_controller;
    import sar_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    localparam sar_word_t ALL1 = '1;
    localparam sar_word_t ZERO = '0;

    always #5 CLK = ~CLK;

    sar_if bus ();

    sar_controller #(.SAMPLE_CYCLES(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycle in progress at call time is cycle 1; returns the cycle number in
    // which EOC is seen (budget+1 or more on timeout).
    task automatic wait_eoc(input int budget, output int cyc);
        cyc = 1;
        do begin
            @(negedge CLK);
            cyc++;
        end while (bus.EOC !== 1'b1 && cyc <= budget);
    endtask

    task automatic reset_and_release();
        RST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic check_reset_values(input string name);
        vectors++;
        if (bus.CLKS !== 1'b1 || bus.CLKSB !== 1'b0 || bus.EOC !== 1'b0 ||
            bus.CF !== ZERO || bus.DOUT !== ZERO || bus.CDAC_P !== ZERO || bus.CDAC_N !== ZERO) begin
            miscompares++;
            $display("FAIL %s: CLKS=%b CLKSB=%b EOC=%b CF=%b DOUT=%b CDAC_P=%b CDAC_N=%b, required CLKS=1 CLKSB=0 EOC=0 and all words zero",
                     name, bus.CLKS, bus.CLKSB, bus.EOC, bus.CF, bus.DOUT, bus.CDAC_P, bus.CDAC_N);
        end
    endtask

    task automatic test_reset();
        int cyc;
        bus.COMP_P = 1'b1;
        bus.COMP_N = 1'b0;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_values("reset_held");
        RST = 1'b1;
        wait_eoc(20, cyc);
        vectors++;
        if (bus.DOUT !== ALL1) begin
            miscompares++;
            $display("FAIL reset_precondition_dout: got %b, required %b", bus.DOUT, ALL1);
        end
        // EOC cycle + SAMPLE + three CONV bits: CDAC_P partially set.
        repeat (5) @(negedge CLK);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1 check_reset_values("reset_async_mid_conv");
        @(negedge CLK);
        check_reset_values("reset_hold_after_edge");
    endtask

    task automatic test_const(input logic d, input string name);
        int        cyc;
        sar_word_t exp;
        exp = d ? ALL1 : ZERO;
        bus.COMP_P = d;
        bus.COMP_N = ~d;
        reset_and_release();
        wait_eoc(20, cyc);
        vectors++;
        if (cyc !== 12) begin
            miscompares++;
            $display("FAIL %s_first_eoc_cycle: got %0d, required 12", name, cyc);
        end
        vectors++;
        if (bus.DOUT !== exp || bus.CDAC_P !== exp || bus.CDAC_N !== ~exp || bus.CF !== ZERO || bus.CLKS !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: DOUT=%b CDAC_P=%b CDAC_N=%b CF=%b CLKS=%b, required DOUT=CDAC_P=%b CDAC_N=%b CF=0 CLKS=0",
                     name, bus.DOUT, bus.CDAC_P, bus.CDAC_N, bus.CF, bus.CLKS, exp, ~exp);
        end
        @(negedge CLK);
        vectors++;
        if (bus.EOC !== 1'b0 || bus.CLKS !== 1'b1 || bus.CDAC_P !== ZERO || bus.CDAC_N !== ZERO || bus.DOUT !== exp) begin
            miscompares++;
            $display("FAIL %s_after_eoc: EOC=%b CLKS=%b CDAC_P=%b CDAC_N=%b DOUT=%b, required EOC=0 CLKS=1 CDACs zero DOUT=%b",
                     name, bus.EOC, bus.CLKS, bus.CDAC_P, bus.CDAC_N, bus.DOUT, exp);
        end
        // Now in SAMPLE; the next EOC lands 12 cycles after the previous one.
        wait_eoc(20, cyc);
        vectors++;
        if (cyc !== 12 || bus.DOUT !== exp) begin
            miscompares++;
            $display("FAIL %s_period: EOC in cycle %0d DOUT=%b, required cycle 12 DOUT=%b", name, cyc, bus.DOUT, exp);
        end
    endtask

    task automatic test_pattern();
        sar_word_t pat;
        sar_word_t oh;
        pat = 10'b1011001010;
        bus.COMP_P = 1'b0;
        bus.COMP_N = 1'b1;
        reset_and_release();
        vectors++;
        if (bus.CLKS !== 1'b1 || bus.CF !== ZERO) begin
            miscompares++;
            $display("FAIL pattern_sample: CLKS=%b CF=%b, required CLKS=1 CF=0", bus.CLKS, bus.CF);
        end
        for (int k = 0; k < N_BITS; k++) begin
            @(negedge CLK);
            oh = '0;
            oh[k] = 1'b1;
            vectors++;
            if (bus.CF !== oh || bus.CLKS !== 1'b0) begin
                miscompares++;
                $display("FAIL pattern_cf_bit%0d: CF=%b CLKS=%b, required CF=%b CLKS=0", k, bus.CF, bus.CLKS, oh);
            end
            bus.COMP_P = pat[k];
            bus.COMP_N = ~pat[k];
        end
        @(negedge CLK);
        vectors++;
        if (bus.EOC !== 1'b1 || bus.DOUT !== pat || bus.CDAC_P !== pat || bus.CDAC_N !== ~pat) begin
            miscompares++;
            $display("FAIL pattern_result: EOC=%b DOUT=%b CDAC_P=%b CDAC_N=%b, required EOC=1 DOUT=CDAC_P=%b CDAC_N=%b",
                     bus.EOC, bus.DOUT, bus.CDAC_P, bus.CDAC_N, pat, ~pat);
        end
    endtask

    task automatic test_random();
        sar_word_t exp;
        sar_word_t prev_dout;
        logic      prev_eoc;
        logic      d;
        int        last_eoc;
        int        eoc_count;
        exp       = '0;
        prev_dout = '0;
        prev_eoc  = 1'b0;
        last_eoc  = -1;
        eoc_count = 0;
        reset_and_release();
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            vectors++;
            if (bus.CLKSB !== ~bus.CLKS) begin
                miscompares++;
                $display("FAIL rand_clksb c%0d: CLKS=%b CLKSB=%b, required complement", c, bus.CLKS, bus.CLKSB);
            end
            vectors++;
            if (!$onehot0(bus.CF) || (bus.CF !== ZERO && bus.CLKS !== 1'b0)) begin
                miscompares++;
                $display("FAIL rand_cf c%0d: CF=%b CLKS=%b, required one-hot/zero and CLKS=0 when set", c, bus.CF, bus.CLKS);
            end
            vectors++;
            if ((bus.CDAC_P & bus.CDAC_N) !== ZERO) begin
                miscompares++;
                $display("FAIL rand_cdac_overlap c%0d: P=%b N=%b, required disjoint", c, bus.CDAC_P, bus.CDAC_N);
            end
            vectors++;
            if (bus.EOC === 1'b1 && prev_eoc === 1'b1) begin
                miscompares++;
                $display("FAIL rand_eoc_width c%0d: EOC high 2 cycles, required 1", c);
            end
            if (bus.EOC === 1'b1) begin
                eoc_count++;
                vectors++;
                if (bus.DOUT !== exp) begin
                    miscompares++;
                    $display("FAIL rand_dout c%0d: got %b, required %b", c, bus.DOUT, exp);
                end
                if (last_eoc >= 0) begin
                    vectors++;
                    if (c - last_eoc !== 12) begin
                        miscompares++;
                        $display("FAIL rand_period c%0d: got %0d, required 12", c, c - last_eoc);
                    end
                end
                last_eoc = c;
            end else begin
                vectors++;
                if (bus.DOUT !== prev_dout) begin
                    miscompares++;
                    $display("FAIL rand_dout_stable c%0d: got %b, required %b", c, bus.DOUT, prev_dout);
                end
            end
            d = 1'($urandom_range(0, 1));
            for (int k = 0; k < N_BITS; k++) begin
                if (bus.CF[k] === 1'b1) exp[k] = d;
            end
            bus.COMP_P = d;
            bus.COMP_N = ~d;
            prev_eoc  = bus.EOC;
            prev_dout = bus.DOUT;
        end
        vectors++;
        if (eoc_count < 15) begin
            miscompares++;
            $display("FAIL rand_eoc_count: got %0d, required at least 15", eoc_count);
        end
    endtask

    task automatic test_tie();
        int cyc;
        int n;
        bus.COMP_P = 1'b1;
        bus.COMP_N = 1'b1;
        reset_and_release();
        wait_eoc(20, cyc);
        vectors++;
        if (cyc !== 12 || bus.DOUT !== ALL1 || bus.CDAC_P !== ALL1 || bus.CDAC_N !== ZERO) begin
            miscompares++;
            $display("FAIL tie_result: cycle %0d DOUT=%b CDAC_P=%b CDAC_N=%b, required cycle 12 DOUT=CDAC_P=all-1 CDAC_N=0",
                     cyc, bus.DOUT, bus.CDAC_P, bus.CDAC_N);
        end
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.CF[5] !== 1'b1 && n < 30);
        vectors++;
        if (bus.CF[5] !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_reach_bit5: CF=%b, required CF[5]=1", bus.CF);
        end
        RST = 1'b0;
        #1 check_reset_values("tie_reset_bit5");
        @(negedge CLK);
        RST = 1'b1;
        wait_eoc(20, cyc);
        vectors++;
        if (cyc !== 12 || bus.DOUT !== ALL1) begin
            miscompares++;
            $display("FAIL tie_after_reset: EOC in cycle %0d DOUT=%b, required cycle 12 DOUT=all-1", cyc, bus.DOUT);
        end
    endtask

    initial begin
        bus.COMP_P = 1'b0;
        bus.COMP_N = 1'b1;
        test_reset();
        test_const(1'b1, "ones");
        test_const(1'b0, "zeros");
        test_pattern();
        test_random();
        test_tie();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
